timer_dev: RTL



---
 rtl/timer_defs.sv | 41 ++++
 rtl/timer_prescaler.sv | 29 ++
 rtl/timer_dev.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/timer_defs.sv
// Shared definitions for the memory-mapped countdown timer (timer_dev).
// TIMER_PRESCALE_EN enables the optional PRESCALE register at offset 3.
package timer_defs;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned ADDR_W     = 2;
  localparam int unsigned BE_W       = DATA_W / 8;
  localparam int unsigned CTRL_W     = 4;
  localparam int unsigned PRESCALE_W = 16;

  localparam logic [ADDR_W-1:0] TIMER_CTRL     = 2'd0;
  localparam logic [ADDR_W-1:0] TIMER_PRESET   = 2'd1;
  localparam logic [ADDR_W-1:0] TIMER_COUNT    = 2'd2;
  localparam logic [ADDR_W-1:0] TIMER_PRESCALE = 2'd3;

  localparam int unsigned CTRL_EN_BIT   = 0;
  localparam int unsigned CTRL_MODE_LSB = 1;
  localparam int unsigned CTRL_MODE_MSB = 2;
  localparam int unsigned CTRL_IM_BIT   = 3;

  localparam logic [1:0] MODE_ONESHOT = 2'd0;
  localparam logic [1:0] MODE_RELOAD  = 2'd1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_CNT  = 2'd2;
  localparam logic [1:0] ST_INT  = 2'd3;

  // Replace the byte lanes of old_v selected by be with the lanes of new_v.
  function automatic logic [DATA_W-1:0] merge_bytes(input logic [DATA_W-1:0] old_v,
                                                     input logic [DATA_W-1:0] new_v,
                                                     input logic [BE_W-1:0]   be);
    logic [DATA_W-1:0] res;
    res = old_v;
    for (int i = 0; i < int'(BE_W); i++) begin
      if (be[i]) res[8*i +: 8] = new_v[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Tick divider for timer_dev: one tick every divisor+1 cycles, restarted by load.
// Only built when TIMER_PRESCALE_EN is defined.
`ifdef TIMER_PRESCALE_EN
module timer_prescaler
  import timer_defs::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [PRESCALE_W-1:0] divisor,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] r_cnt;

  assign tick = (r_cnt == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (load || tick) begin
      r_cnt <= divisor;
    end else begin
      r_cnt <= r_cnt - PRESCALE_W'(1);
    end
  end

endmodule
`endif

// File: rtl/timer_dev.sv
// Memory-mapped countdown timer with one-shot / auto-reload modes and masked irq.
// TIMER_PRESCALE_EN adds a 16-bit PRESCALE register at offset 3 and a tick divider.
module timer_dev
  import timer_defs::*;
#(
  parameter logic [DATA_W-1:0] RESET_PRESET = 32'h0
)
(
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr,
  input  logic              we,
  input  logic [BE_W-1:0]   byteen,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              irq
);

  logic [1:0]        r_state,    w_state_nxt;
  logic [CTRL_W-1:0] r_ctrl,     w_ctrl_nxt;
  logic [DATA_W-1:0] r_preset,   w_preset_nxt;
  logic [DATA_W-1:0] r_count,    w_count_nxt;
  logic              r_irq_flag, w_irq_flag_nxt;
  logic [1:0]        w_mode;
  logic              w_reload;
  logic              w_tick;
  logic              w_wr_ctrl;
  logic              w_wr_preset;

  // Reserved mode encodings fold to one-shot.
  assign w_mode      = (r_ctrl[CTRL_MODE_MSB:CTRL_MODE_LSB] == MODE_RELOAD) ? MODE_RELOAD : MODE_ONESHOT;
  assign w_reload    = (w_mode == MODE_RELOAD);
  assign w_wr_ctrl   = we && (addr == TIMER_CTRL) && byteen[0];
  assign w_wr_preset = we && (addr == TIMER_PRESET);

`ifdef TIMER_PRESCALE_EN
  logic [PRESCALE_W-1:0] r_prescale, w_prescale_nxt;

  timer_prescaler u_prescaler (
    .clk     (clk),
    .reset   (reset),
    .load    (r_state == ST_LOAD),
    .divisor (r_prescale),
    .tick    (w_tick)
  );

  always_comb begin
    w_prescale_nxt = r_prescale;
    if (we && (addr == TIMER_PRESCALE)) begin
      if (byteen[0]) w_prescale_nxt[7:0]  = wdata[7:0];
      if (byteen[1]) w_prescale_nxt[15:8] = wdata[15:8];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_prescale <= '0;
    else        r_prescale <= w_prescale_nxt;
  end
`else
  assign w_tick = 1'b1;
`endif

  // Next-state, counter and flag logic; software CTRL writes override hardware updates.
  always_comb begin
    w_state_nxt    = r_state;
    w_ctrl_nxt     = r_ctrl;
    w_preset_nxt   = r_preset;
    w_count_nxt    = r_count;
    w_irq_flag_nxt = r_irq_flag;

    case (r_state)
      ST_IDLE: begin
        if (r_ctrl[CTRL_EN_BIT]) w_state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        w_count_nxt = r_preset;
        w_state_nxt = ST_CNT;
      end
      ST_CNT: begin
        if (!r_ctrl[CTRL_EN_BIT]) begin
          w_state_nxt = ST_IDLE;
        end else if (w_tick) begin
          if (r_count != '0) begin
            w_count_nxt = r_count - DATA_W'(1);
          end else begin
            w_state_nxt    = ST_INT;
            w_irq_flag_nxt = 1'b1;
          end
        end
      end
      ST_INT: begin
        if (w_reload) begin
          w_irq_flag_nxt = 1'b0;
          w_state_nxt    = ST_LOAD;
        end else begin
          w_ctrl_nxt[CTRL_EN_BIT] = 1'b0;
          w_state_nxt             = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    if (w_wr_ctrl) begin
      w_ctrl_nxt = wdata[CTRL_W-1:0];
      if (!w_reload) w_irq_flag_nxt = 1'b0;
    end
    if (w_wr_preset) begin
      w_preset_nxt = merge_bytes(r_preset, wdata, byteen);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_ctrl     <= '0;
      r_preset   <= RESET_PRESET;
      r_count    <= '0;
      r_irq_flag <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_ctrl     <= w_ctrl_nxt;
      r_preset   <= w_preset_nxt;
      r_count    <= w_count_nxt;
      r_irq_flag <= w_irq_flag_nxt;
    end
  end

  always_comb begin
    rdata = '0;
    case (addr)
      TIMER_CTRL:     rdata = DATA_W'(r_ctrl);
      TIMER_PRESET:   rdata = r_preset;
      TIMER_COUNT:    rdata = r_count;
`ifdef TIMER_PRESCALE_EN
      TIMER_PRESCALE: rdata = DATA_W'(r_prescale);
`else
      TIMER_PRESCALE: rdata = '0;
`endif
      default:        rdata = '0;
    endcase
  end

  assign irq = r_irq_flag & r_ctrl[CTRL_IM_BIT];

endmodule
